pong_round_controller: RTL



---
 rtl/pong_round_controller_if.sv | 43 ++++
 rtl/pong_round_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_round_controller_if.sv
// -----------------------------------------------------------------------------
// pong_round_controller_if
// Bundles the game-flow signals between the Pong round controller and the rest
// of the image generator (frame timing, ball datapath, score display).
//
// Signals:
//   frame_tick  one-cycle pulse per frame (end of visible area)
//   start       level request to start or restart a game
//   ball_x      current ball left-edge x position (12 bits)
//   ball_reset  one-cycle pulse: load ball to centre and set its direction
//   ball_run    1 = ball datapath may move
//   serve_left  serve direction sampled by the ball on ball_reset
//   score_1     player 1 score (4 bits)
//   score_2     player 2 score (4 bits)
//   winner      00 none, 01 player 1, 10 player 2
//   state       current controller state encoding
//
// Modports:
//   master  the round controller (consumes timing/ball position, drives flow)
//   slave   the surrounding game logic
// -----------------------------------------------------------------------------
interface pong_round_controller_if;
  logic        frame_tick;
  logic        start;
  logic [11:0] ball_x;
  logic        ball_reset;
  logic        ball_run;
  logic        serve_left;
  logic [3:0]  score_1;
  logic [3:0]  score_2;
  logic [1:0]  winner;
  logic [2:0]  state;

  modport master (
    input  frame_tick, start, ball_x,
    output ball_reset, ball_run, serve_left, score_1, score_2, winner, state
  );

  modport slave (
    output frame_tick, start, ball_x,
    input  ball_reset, ball_run, serve_left, score_1, score_2, winner, state
  );
endinterface

// File: rtl/pong_round_controller.sv
// -----------------------------------------------------------------------------
// pong_round_controller
// Game-flow sequencer for the Pong image generator. Decides when the ball is
// frozen, re-centred, served or free-running, detects goals from the ball
// x-position, keeps both scores and declares a winner. Runs on the pixel clock;
// timed phases (serve hold, post-goal freeze) advance on the per-frame tick.
//
// Ports:
//   CLOCK_25  25 MHz pixel clock
//   reset_n   asynchronous active-low reset
//   bus       pong_round_controller_if.master (see interface for signal list)
//
// Optional build macro:
//   AUTO_RESTART_EN  when defined, the game-over phase times out after
//                    2*POINT_FRAMES frames and serves a fresh game on its own;
//                    when undefined, game over waits for start indefinitely.
// -----------------------------------------------------------------------------
module pong_round_controller #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int LEFT_GOAL_X  = 4,
  parameter int RIGHT_GOAL_X = 627,
  parameter int FRAME_CNT_W  = 8
) (
  input  logic                    CLOCK_25,
  input  logic                    reset_n,
  pong_round_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [3:0]             C_WIN          = 4'(WIN_SCORE);
  localparam logic [11:0]            C_LEFT_GOAL_X  = 12'(LEFT_GOAL_X);
  localparam logic [11:0]            C_RIGHT_GOAL_X = 12'(RIGHT_GOAL_X);
  // Ball is 10 pixels wide: its right edge sits 9 pixels past ball_x.
  localparam logic [11:0]            C_BALL_EDGE    = 12'd9;
  localparam logic [FRAME_CNT_W-1:0] C_CNT_ZERO     = {FRAME_CNT_W{1'b0}};
  localparam logic [FRAME_CNT_W-1:0] C_CNT_ONE      = FRAME_CNT_W'(1);
  // A zero-length phase would never expire on a tick, so it is stretched to one.
  localparam logic [FRAME_CNT_W-1:0] C_SERVE_LOAD   =
    (SERVE_FRAMES == 0) ? C_CNT_ONE : FRAME_CNT_W'(SERVE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] C_POINT_LOAD   =
    (POINT_FRAMES == 0) ? C_CNT_ONE : FRAME_CNT_W'(POINT_FRAMES);
`ifdef AUTO_RESTART_EN
  localparam logic [FRAME_CNT_W-1:0] C_OVER_LOAD    =
    (POINT_FRAMES == 0) ? C_CNT_ONE : FRAME_CNT_W'(POINT_FRAMES * 2);
`endif

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [FRAME_CNT_W-1:0] w_frame_cnt_nxt;
  logic                   r_ball_reset;
  logic                   w_ball_reset_nxt;
  logic                   r_ball_run;
  logic                   w_ball_run_nxt;
  logic                   r_serve_left;
  logic                   w_serve_left_nxt;
  logic [3:0]             r_score_1;
  logic [3:0]             w_score_1_nxt;
  logic [3:0]             r_score_2;
  logic [3:0]             w_score_2_nxt;
  logic [1:0]             r_winner;
  logic [1:0]             w_winner_nxt;

  logic [11:0]            w_ball_right_x;
  logic                   w_left_goal;
  logic                   w_right_goal;
  logic                   w_expire;
  logic                   w_game_won;
  logic [FRAME_CNT_W-1:0] w_cnt_dec;

  // Score increment that sticks at the winning score instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    logic [3:0] res;
    if (v >= C_WIN) begin
      res = v;
    end else begin
      res = v + 4'd1;
    end
    return res;
  endfunction

  // 12-bit sum on purpose: the legal ball range never reaches the wrap point.
  assign w_ball_right_x = bus.ball_x + C_BALL_EDGE;
  assign w_left_goal    = (bus.ball_x <= C_LEFT_GOAL_X);
  assign w_right_goal   = (w_ball_right_x >= C_RIGHT_GOAL_X);
  // Expiry is the tick that would take the counter from 1 to 0.
  assign w_expire       = bus.frame_tick & (r_frame_cnt <= C_CNT_ONE);
  assign w_cnt_dec      = (r_frame_cnt == C_CNT_ZERO) ? C_CNT_ZERO : (r_frame_cnt - C_CNT_ONE);
  assign w_game_won     = (r_score_1 == C_WIN) | (r_score_2 == C_WIN);

  // State register.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_SERVE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SERVE: begin
        if (w_expire) begin
          w_state_nxt = S_PLAY;
        end else begin
          w_state_nxt = S_SERVE;
        end
      end
      S_PLAY: begin
        if (w_left_goal || w_right_goal) begin
          w_state_nxt = S_POINT;
        end else begin
          w_state_nxt = S_PLAY;
        end
      end
      S_POINT: begin
        if (w_expire && w_game_won) begin
          w_state_nxt = S_OVER;
        end else if (w_expire) begin
          w_state_nxt = S_SERVE;
        end else begin
          w_state_nxt = S_POINT;
        end
      end
      S_OVER: begin
        if (bus.start) begin
          w_state_nxt = S_SERVE;
        end
`ifdef AUTO_RESTART_EN
        else if (w_expire) begin
          w_state_nxt = S_SERVE;
        end
`endif
        else begin
          w_state_nxt = S_OVER;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next values for the registered outputs, scores and frame counter.
  always_comb begin
    w_ball_reset_nxt = 1'b0;
    w_ball_run_nxt   = (w_state_nxt == S_PLAY);
    w_serve_left_nxt = r_serve_left;
    w_score_1_nxt    = r_score_1;
    w_score_2_nxt    = r_score_2;
    w_winner_nxt     = r_winner;
    w_frame_cnt_nxt  = r_frame_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_score_1_nxt    = 4'd0;
          w_score_2_nxt    = 4'd0;
          w_winner_nxt     = 2'b00;
          w_serve_left_nxt = 1'b0;
          w_ball_reset_nxt = 1'b1;
          w_frame_cnt_nxt  = C_SERVE_LOAD;
        end else begin
          w_frame_cnt_nxt  = r_frame_cnt;
        end
      end
      S_SERVE: begin
        if (bus.frame_tick) begin
          w_frame_cnt_nxt = w_cnt_dec;
        end else begin
          w_frame_cnt_nxt = r_frame_cnt;
        end
      end
      S_PLAY: begin
        // Left goal wins the tie; leaving PLAY at once limits it to one goal.
        if (w_left_goal) begin
          w_score_2_nxt    = sat_inc(r_score_2);
          w_serve_left_nxt = 1'b1;
          w_frame_cnt_nxt  = C_POINT_LOAD;
        end else if (w_right_goal) begin
          w_score_1_nxt    = sat_inc(r_score_1);
          w_serve_left_nxt = 1'b0;
          w_frame_cnt_nxt  = C_POINT_LOAD;
        end else begin
          w_frame_cnt_nxt  = r_frame_cnt;
        end
      end
      S_POINT: begin
        if (w_expire && w_game_won) begin
          if (r_score_1 == C_WIN) begin
            w_winner_nxt = 2'b01;
          end else begin
            w_winner_nxt = 2'b10;
          end
`ifdef AUTO_RESTART_EN
          w_frame_cnt_nxt = C_OVER_LOAD;
`else
          w_frame_cnt_nxt = C_CNT_ZERO;
`endif
        end else if (w_expire) begin
          w_ball_reset_nxt = 1'b1;
          w_frame_cnt_nxt  = C_SERVE_LOAD;
        end else if (bus.frame_tick) begin
          w_frame_cnt_nxt  = w_cnt_dec;
        end else begin
          w_frame_cnt_nxt  = r_frame_cnt;
        end
      end
      S_OVER: begin
        if (bus.start) begin
          w_score_1_nxt    = 4'd0;
          w_score_2_nxt    = 4'd0;
          w_winner_nxt     = 2'b00;
          w_serve_left_nxt = 1'b0;
          w_ball_reset_nxt = 1'b1;
          w_frame_cnt_nxt  = C_SERVE_LOAD;
        end
`ifdef AUTO_RESTART_EN
        else if (w_expire) begin
          w_score_1_nxt    = 4'd0;
          w_score_2_nxt    = 4'd0;
          w_winner_nxt     = 2'b00;
          w_serve_left_nxt = 1'b0;
          w_ball_reset_nxt = 1'b1;
          w_frame_cnt_nxt  = C_SERVE_LOAD;
        end else if (bus.frame_tick) begin
          w_frame_cnt_nxt  = w_cnt_dec;
        end
`endif
        else begin
          w_frame_cnt_nxt  = r_frame_cnt;
        end
      end
      default: begin
        w_frame_cnt_nxt = C_CNT_ZERO;
      end
    endcase
  end

  // Output and datapath registers; reset drops any pending pulse immediately.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_ball_reset <= 1'b0;
      r_ball_run   <= 1'b0;
      r_serve_left <= 1'b0;
      r_score_1    <= 4'd0;
      r_score_2    <= 4'd0;
      r_winner     <= 2'b00;
      r_frame_cnt  <= C_CNT_ZERO;
    end else begin
      r_ball_reset <= w_ball_reset_nxt;
      r_ball_run   <= w_ball_run_nxt;
      r_serve_left <= w_serve_left_nxt;
      r_score_1    <= w_score_1_nxt;
      r_score_2    <= w_score_2_nxt;
      r_winner     <= w_winner_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
    end
  end

  assign bus.ball_reset = r_ball_reset;
  assign bus.ball_run   = r_ball_run;
  assign bus.serve_left = r_serve_left;
  assign bus.score_1    = r_score_1;
  assign bus.score_2    = r_score_2;
  assign bus.winner     = r_winner;
  assign bus.state      = r_state;

endmodule
